// File: rtl/hazard_pipeline_controller.sv
// Destination-tag shadow pipeline (EX/MEM/WB) that generates load-use stalls,
// branch flushes, operand-forwarding selects and the register-file write port.
module hazard_pipeline_controller #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_branch_taken,
    input  logic             mem_wait,
    output logic             pc_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [REG_W-1:0] wb_rd,
    output logic             wb_we,
    output logic [CNT_W-1:0] stall_count
);
    typedef enum logic {RUN, LOAD_STALL} state_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } tag_t;

    tag_t             ex_q, mem_q, wb_q, ex_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             post_rst_q;
    logic             quiet, wait_eff, branch_eff, load_use;
    logic             stall_c, flush_c, bubble_c, freeze_c;
    logic [1:0][1:0]       fwd_sel;
    logic [1:0][REG_W-1:0] rs;
    logic             unused_wb_memread;

    // Outputs stay silent in the reset cycle and the one right after it.
    assign quiet      = reset | post_rst_q;
    assign wait_eff   = mem_wait & ~post_rst_q;
    assign branch_eff = ex_branch_taken & ~post_rst_q;

    assign load_use = id_valid & ex_q.valid & ex_q.memread & ex_q.regwrite &
                      (ex_q.rd != '0) &
                      ((id_use_rs1 & (id_rs1 == ex_q.rd)) |
                       (id_use_rs2 & (id_rs2 == ex_q.rd)));

    always_comb begin
        stall_c  = 1'b0;
        flush_c  = 1'b0;
        bubble_c = 1'b0;
        freeze_c = 1'b0;
        state_d  = RUN;
        cnt_d    = cnt_q;
        if (wait_eff) begin
            freeze_c = 1'b1;
            state_d  = state_q;
        end else if (branch_eff) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
        end else if (load_use) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            state_d  = LOAD_STALL;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        ex_d = '0;
        if (!bubble_c) begin
            ex_d.valid    = id_valid;
            ex_d.rd       = id_rd;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            state_q    <= RUN;
            cnt_q      <= '0;
            post_rst_q <= 1'b1;
        end else begin
            post_rst_q <= 1'b0;
            if (!wait_eff) begin
                ex_q  <= ex_d;
                mem_q <= ex_q;
                wb_q  <= mem_q;
            end
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rs[0] = id_rs1;
    assign rs[1] = id_rs2;

    // A load still in EX cannot forward; the stall covers that case instead.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic hit_ex, hit_mem, hit_wb;
        assign hit_ex  = ex_q.valid & ex_q.regwrite & (ex_q.rd != '0) &
                         (ex_q.rd == rs[gi]) & ~load_use;
        assign hit_mem = mem_q.valid & mem_q.regwrite & (mem_q.rd != '0) &
                         (mem_q.rd == rs[gi]);
        assign hit_wb  = wb_q.valid & wb_q.regwrite & (wb_q.rd != '0) &
                         (wb_q.rd == rs[gi]);
        assign fwd_sel[gi] = hit_ex  ? 2'b01 :
                             hit_mem ? 2'b10 :
                             hit_wb  ? 2'b11 : 2'b00;
    end

    assign pc_stall     = stall_c  & ~quiet;
    assign if_id_flush  = flush_c  & ~quiet;
    assign id_ex_bubble = bubble_c & ~quiet;
    assign freeze       = freeze_c & ~quiet;
    assign fwd_a        = quiet ? 2'b00 : fwd_sel[0];
    assign fwd_b        = quiet ? 2'b00 : fwd_sel[1];
    assign wb_we        = ~quiet & wb_q.valid & wb_q.regwrite & (wb_q.rd != '0);
    assign wb_rd        = quiet ? '0 : wb_q.rd;
    assign stall_count  = quiet ? '0 : cnt_q;

    assign unused_wb_memread = wb_q.memread;
endmodule

// File: tb/tb_hazard_pipeline_controller.sv
// Bench for hazard_pipeline_controller: directed scenarios plus a randomized
// run checked against a stage-list reference model.
module tb_hazard_pipeline_controller;
    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             id_valid = 1'b0;
    logic [REG_W-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic             id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic             id_regwrite = 1'b0, id_memread = 1'b0;
    logic             ex_branch_taken = 1'b0, mem_wait = 1'b0;
    logic             pc_stall, if_id_flush, id_ex_bubble, freeze, wb_we;
    logic [1:0]       fwd_a, fwd_b;
    logic [REG_W-1:0] wb_rd;
    logic [CNT_W-1:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_pipeline_controller #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
        .pc_stall(pc_stall), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .freeze(freeze), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .wb_rd(wb_rd), .wb_we(wb_we), .stall_count(stall_count)
    );

    // Reference model: index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             ld;
    } mtag_t;

    mtag_t m_pipe [3];
    int    m_cnt = 0;
    bit    m_post = 1'b0;

    function automatic logic model_lu();
        return id_valid && m_pipe[0].v && m_pipe[0].ld && m_pipe[0].we &&
               (m_pipe[0].rd != 0) &&
               ((id_use_rs1 && id_rs1 == m_pipe[0].rd) ||
                (id_use_rs2 && id_rs2 == m_pipe[0].rd));
    endfunction

    // Oldest matching stage first, younger matches override.
    function automatic logic [1:0] model_fwd(input logic [REG_W-1:0] r);
        logic [1:0] sel = 2'b00;
        for (int k = 2; k >= 0; k--) begin
            if (!(k == 0 && model_lu()) && m_pipe[k].v && m_pipe[k].we &&
                m_pipe[k].rd != 0 && m_pipe[k].rd == r)
                sel = 2'(k + 1);
        end
        return sel;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) m_pipe[k] <= '0;
            m_cnt  <= 0;
            m_post <= 1'b1;
        end else begin
            m_post <= 1'b0;
            if (m_post || !mem_wait) begin
                m_pipe[2] <= m_pipe[1];
                m_pipe[1] <= m_pipe[0];
                if (!m_post && (ex_branch_taken || model_lu()))
                    m_pipe[0] <= '0;
                else
                    m_pipe[0] <= '{id_valid, id_rd, id_regwrite, id_memread};
                if (!m_post && !ex_branch_taken && model_lu())
                    m_cnt <= (m_cnt + 1) % (1 << CNT_W);
            end
        end
    end

    task automatic set_id(input logic v, input logic [REG_W-1:0] rs1,
                          input logic [REG_W-1:0] rs2, input logic u1,
                          input logic u2, input logic [REG_W-1:0] rd,
                          input logic rw, input logic mr);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1;
        id_use_rs2 = u2; id_rd = rd; id_regwrite = rw; id_memread = mr;
    endtask

    task automatic set_ctl(input logic br, input logic mw);
        ex_branch_taken = br; mem_wait = mw;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_ctl(0, 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        next_cycle();
        next_cycle();
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        logic [17:0] all_o;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_id(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
                   1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
            set_ctl(1'($urandom), 1'($urandom));
            @(negedge clk);
            all_o = {pc_stall, if_id_flush, id_ex_bubble, freeze, fwd_a, fwd_b,
                     wb_rd, wb_we, stall_count};
            n_cmp++;
            if (all_o !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs cycle %0d: got %h want 0", i, all_o);
            end
            next_cycle();
        end
        reset = 1'b0;
        idle();
        set_id(1, 0, 0, 0, 0, 5'd5, 1, 0);
        @(negedge clk);
        all_o = {pc_stall, if_id_flush, id_ex_bubble, freeze, fwd_a, fwd_b,
                 wb_rd, wb_we, stall_count};
        n_cmp++;
        if (all_o !== '0) begin
            n_bad++;
            $display("FAIL post_reset_outputs: got %h want 0", all_o);
        end
        next_cycle();
        idle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (wb_we !== 1'b0) begin
                n_bad++;
                $display("FAIL wb_early stage %0d: wb_we got %b want 0", i, wb_we);
            end
            next_cycle();
        end
        @(negedge clk);
        n_cmp++;
        if (wb_rd !== 5'd5 || wb_we !== 1'b1 || stall_count !== '0) begin
            n_bad++;
            $display("FAIL wb_latency: wb_rd=%0d wb_we=%b cnt=%0d want 5/1/0",
                     wb_rd, wb_we, stall_count);
        end
        $display("test_reset: done, wb_rd=%0d wb_we=%b", wb_rd, wb_we);
        next_cycle();
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 0, 0, 0, 0, 5'd7, 1, 1);
        next_cycle();
        set_id(1, 5'd7, 5'd2, 1, 1, 5'd8, 1, 0);
        @(negedge clk);
        n_cmp++;
        if ({pc_stall, id_ex_bubble, if_id_flush} !== 3'b110 || fwd_a !== 2'b00) begin
            n_bad++;
            $display("FAIL load_use_stall: stall/bubble/flush=%b%b%b fwd_a=%b want 110/00",
                     pc_stall, id_ex_bubble, if_id_flush, fwd_a);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (pc_stall !== 1'b0 || id_ex_bubble !== 1'b0 || stall_count !== 4'd1 ||
            fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
            n_bad++;
            $display("FAIL load_use_after: stall=%b bubble=%b cnt=%0d fwd_a=%b fwd_b=%b want 0/0/1/10/00",
                     pc_stall, id_ex_bubble, stall_count, fwd_a, fwd_b);
        end
        $display("test_load_use: cnt=%0d fwd_a=%b", stall_count, fwd_a);
        next_cycle();
        idle();
    endtask

    task automatic test_fwd_priority();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_id(1, 0, 0, 0, 0, 5'd3, 1, 0);
            next_cycle();
        end
        set_id(1, 5'd3, 0, 1, 0, 5'd9, 1, 0);
        @(negedge clk);
        n_cmp++;
        if (fwd_a !== 2'b01 || pc_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL fwd_ex_wins: fwd_a=%b stall=%b want 01/0", fwd_a, pc_stall);
        end
        next_cycle();
        do_reset();
        set_id(1, 0, 0, 0, 0, 5'd3, 1, 0);
        next_cycle();
        set_id(1, 0, 0, 0, 0, 5'd4, 1, 0);
        next_cycle();
        idle();
        next_cycle();
        set_id(1, 5'd3, 5'd4, 1, 1, 5'd10, 1, 0);
        @(negedge clk);
        n_cmp++;
        if (fwd_a !== 2'b11 || fwd_b !== 2'b10) begin
            n_bad++;
            $display("FAIL fwd_wb_mem: fwd_a=%b fwd_b=%b want 11/10", fwd_a, fwd_b);
        end
        $display("test_fwd_priority: fwd_a=%b fwd_b=%b", fwd_a, fwd_b);
        next_cycle();
        idle();
    endtask

    task automatic test_x0();
        do_reset();
        set_id(1, 0, 0, 0, 0, 5'd0, 1, 0);
        next_cycle();
        set_id(1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            n_bad++;
            $display("FAIL fwd_x0: fwd_a=%b fwd_b=%b want 00/00", fwd_a, fwd_b);
        end
        next_cycle();
        idle();
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (wb_we !== 1'b0) begin
            n_bad++;
            $display("FAIL wb_x0: wb_we=%b want 0", wb_we);
        end
        $display("test_x0: fwd_a=%b wb_we=%b", fwd_a, wb_we);
        next_cycle();
    endtask

    task automatic test_branch_vs_load();
        do_reset();
        set_id(1, 0, 0, 0, 0, 5'd7, 1, 1);
        next_cycle();
        set_id(1, 5'd7, 0, 1, 0, 5'd8, 1, 0);
        set_ctl(1, 0);
        @(negedge clk);
        n_cmp++;
        if (if_id_flush !== 1'b1 || id_ex_bubble !== 1'b1 || pc_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL branch_over_load: flush=%b bubble=%b stall=%b want 1/1/0",
                     if_id_flush, id_ex_bubble, pc_stall);
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_cmp++;
        if (stall_count !== '0 || pc_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL branch_no_count: cnt=%0d stall=%b want 0/0", stall_count, pc_stall);
        end
        $display("test_branch_vs_load: cnt=%0d", stall_count);
        next_cycle();
    endtask

    task automatic load_use_pair();
        set_id(1, 0, 0, 0, 0, 5'd7, 1, 1);
        next_cycle();
        set_id(1, 5'd1, 5'd7, 0, 1, 5'd8, 1, 0);
        next_cycle();
        next_cycle();
        idle();
    endtask

    task automatic test_freeze_wrap();
        do_reset();
        for (int i = 0; i < 14; i++) load_use_pair();
        @(negedge clk);
        n_cmp++;
        if (stall_count !== 4'd14) begin
            n_bad++;
            $display("FAIL preset_count: cnt=%0d want 14", stall_count);
        end
        next_cycle();
        set_id(1, 0, 0, 0, 0, 5'd7, 1, 1);
        next_cycle();
        set_id(1, 5'd7, 5'd0, 1, 0, 5'd8, 1, 0);
        set_ctl(0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (freeze !== 1'b1 || pc_stall !== 1'b0 || id_ex_bubble !== 1'b0 ||
                stall_count !== 4'd14 || fwd_a !== 2'b00) begin
                n_bad++;
                $display("FAIL freeze_hold cycle %0d: frz=%b stall=%b bub=%b cnt=%0d fwd_a=%b want 1/0/0/14/00",
                         i, freeze, pc_stall, id_ex_bubble, stall_count, fwd_a);
            end
            next_cycle();
        end
        set_ctl(0, 0);
        @(negedge clk);
        n_cmp++;
        if (pc_stall !== 1'b1 || freeze !== 1'b0) begin
            n_bad++;
            $display("FAIL release_stall: stall=%b frz=%b want 1/0", pc_stall, freeze);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (pc_stall !== 1'b0 || stall_count !== 4'd15 || fwd_a !== 2'b10) begin
            n_bad++;
            $display("FAIL once_only: stall=%b cnt=%0d fwd_a=%b want 0/15/10",
                     pc_stall, stall_count, fwd_a);
        end
        next_cycle();
        idle();
        load_use_pair();
        @(negedge clk);
        n_cmp++;
        if (stall_count !== 4'd0) begin
            n_bad++;
            $display("FAIL count_wrap: cnt=%0d want 0", stall_count);
        end
        $display("test_freeze_wrap: cnt after wrap=%0d", stall_count);
        next_cycle();
    endtask

    task automatic test_random();
        logic       quiet, lu, e_stall, e_flush, e_bub, e_frz, e_we;
        logic [1:0] e_fa, e_fb;
        logic [REG_W-1:0] e_rd;
        logic [CNT_W-1:0] e_cnt;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                   5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0);
            set_ctl($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
            @(negedge clk);
            quiet   = reset || m_post;
            lu      = model_lu();
            e_frz   = !quiet && mem_wait;
            e_flush = !quiet && !mem_wait && ex_branch_taken;
            e_bub   = !quiet && !mem_wait && (ex_branch_taken || lu);
            e_stall = !quiet && !mem_wait && !ex_branch_taken && lu;
            e_fa    = quiet ? 2'b00 : model_fwd(id_rs1);
            e_fb    = quiet ? 2'b00 : model_fwd(id_rs2);
            e_we    = !quiet && m_pipe[2].v && m_pipe[2].we && m_pipe[2].rd != 0;
            e_rd    = quiet ? '0 : m_pipe[2].rd;
            e_cnt   = quiet ? '0 : CNT_W'(m_cnt);
            n_cmp++;
            if ({pc_stall, if_id_flush, id_ex_bubble, freeze} !== {e_stall, e_flush, e_bub, e_frz}) begin
                n_bad++;
                $display("FAIL rnd_ctrl cycle %0d: got %b want %b", i,
                         {pc_stall, if_id_flush, id_ex_bubble, freeze},
                         {e_stall, e_flush, e_bub, e_frz});
            end
            n_cmp++;
            if ({fwd_a, fwd_b} !== {e_fa, e_fb}) begin
                n_bad++;
                $display("FAIL rnd_fwd cycle %0d: got %b/%b want %b/%b", i,
                         fwd_a, fwd_b, e_fa, e_fb);
            end
            n_cmp++;
            if ({wb_rd, wb_we} !== {e_rd, e_we}) begin
                n_bad++;
                $display("FAIL rnd_wb cycle %0d: got %0d/%b want %0d/%b", i,
                         wb_rd, wb_we, e_rd, e_we);
            end
            n_cmp++;
            if (stall_count !== e_cnt) begin
                n_bad++;
                $display("FAIL rnd_cnt cycle %0d: got %0d want %0d", i, stall_count, e_cnt);
            end
            next_cycle();
        end
        reset = 1'b0;
        idle();
        $display("test_random: 600 cycles, model count=%0d", m_cnt);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_x0();
        test_branch_vs_load();
        test_freeze_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_pipeline_controller.md
Name: hazard_pipeline_controller

Overview:
- Sequences the execute/memory/write-back stages of the RISC-V core.
- Keeps a 3-deep shadow pipeline of destination-register tags (rd, write-enable, load flag, valid) in EX, MEM and WB.
- From those tags it drives load-use stalls, branch flushes, operand-forwarding selects and the register-file write port.
- Sits between decode and the register file; replaces the bare rd delay line.

Parameters:
- REG_W, 5, register-address width.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  processor main clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs1  in  REG_W  source register 1 of the decode instruction.
- id_rs2  in  REG_W  source register 2 of the decode instruction.
- id_use_rs1  in  1  decode instruction reads rs1.
- id_use_rs2  in  1  decode instruction reads rs2.
- id_rd  in  REG_W  destination register of the decode instruction.
- id_regwrite  in  1  decode instruction writes rd.
- id_memread  in  1  decode instruction is a load.
- ex_branch_taken  in  1  instruction in EX resolved a taken branch or jump.
- mem_wait  in  1  data memory not ready; freeze the whole pipeline.
- pc_stall  out  1  hold PC and IF/ID this cycle.
- if_id_flush  out  1  squash the IF/ID register.
- id_ex_bubble  out  1  insert a NOP into ID/EX.
- freeze  out  1  hold all pipeline registers (equals mem_wait).
- fwd_a  out  2  rs1 operand source: 00 regfile, 01 EX result, 10 MEM result, 11 WB result.
- fwd_b  out  2  rs2 operand source, same encoding as fwd_a.
- wb_rd  out  REG_W  register-file write address.
- wb_we  out  1  register-file write enable.
- stall_count  out  CNT_W  count of load-use stall cycles.

Behaviour:
- Registered state:
  - Tag stages EX, MEM, WB, each holding {valid, rd, regwrite, memread}.
  - FSM state: RUN or LOAD_STALL.
  - stall_count.
- Reset (synchronous, priority over everything):
  - All stage valids, rd, regwrite and memread go to 0.
  - FSM goes to RUN; stall_count goes to 0.
  - In the reset cycle and the cycle after, every output is 0: wb_we=0, wb_rd=0, fwd=00, no stall, flush or bubble.
- Combinational hazard detect:
  - load_use = id_valid & EX.valid & EX.memread & EX.regwrite & EX.rd!=0 & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)).
- Output priority, evaluated each cycle:
  1. mem_wait=1: freeze=1; pc_stall, if_id_flush, id_ex_bubble all 0; tag stages and FSM hold; stall_count holds.
  2. ex_branch_taken=1: if_id_flush=1, id_ex_bubble=1, pc_stall=0. Flush wins over load_use, and no stall is counted.
  3. load_use=1: pc_stall=1, id_ex_bubble=1; FSM goes to LOAD_STALL; stall_count increments, wrapping at 2^CNT_W-1 to 0.
  4. Otherwise: all control outputs 0.
- FSM:
  - LOAD_STALL returns to RUN on the next unfrozen edge.
  - Because the bubble removes the load from EX, a stall lasts exactly 1 cycle per load-use pair.
- Tag advance on each posedge without reset or mem_wait:
  - WB <= MEM; MEM <= EX.
  - EX <= bubble (all 0) when id_ex_bubble, else {id_valid, id_rd, id_regwrite, id_memread}.
- Write-back:
  - wb_we = WB.valid & WB.regwrite & WB.rd!=0; wb_rd = WB.rd.
  - Latency: an instruction captured at edge N drives wb_rd/wb_we after edge N+2, i.e. 3 stages.
- Forwarding, per operand, combinational:
  - Match requires stage valid & regwrite & rd!=0 & rd==rs.
  - Priority is EX (01) > MEM (10) > WB (11) > regfile (00).
  - rs=x0 always gives 00.
  - Forwarding from EX is never chosen when load_use is asserted; the stall handles that case.
- Reset in the middle of a stall or freeze clears all state; nothing is carried over.

Test Plan:
- Reset held 2 cycles with random inputs -> all outputs 0, stall_count=0; the first unfrozen ID instruction {rd=5, we=1} gives wb_rd=5, wb_we=1 three edges later.
- Load rd=7 followed by add rs1=7 -> pc_stall=1 and id_ex_bubble=1 for exactly 1 cycle; stall_count=1; next cycle fwd_a=10 (MEM).
- Three back-to-back writers rd=3, rd=3, rd=3, then a reader of x3 -> fwd_a=01 (EX wins). Separately, only WB holding rd=3 -> fwd_a=11.
- Writer to rd=0 ahead of a reader of x0 -> fwd=00 and wb_we=0 when it reaches WB.
- load_use and ex_branch_taken in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_stall=0; stall_count unchanged.
- mem_wait=1 for 3 cycles during a load-use pair -> freeze=1, pc_stall=0, tags and stall_count hold; after release the stall occurs once; stall_count preset near 2^CNT_W-1 wraps to 0.
